// File: rtl/sram_pkg.sv
// Shared types and constants for the 4x4 SRAM array initiator.
package sram_pkg;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 4;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   typedef enum logic [3:0] {
      INIT_SETUP,
      INIT_PULSE,
      INIT_HOLD,
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_SETUP,
      RESP
   } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Host-facing controller for a level-sensitive combinational SRAM array:
// post-reset clear, setup/pulse/hold write phasing, registered read response.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              init_done,
   output logic [ADDR_W-1:0] mem_select,
   output logic              mem_operation,
   output logic              mem_enable,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);

   state_t          state;
   logic [ADDR_W:0] init_cnt;
   logic [ADDR_W:0] cnt_next;

   assign cnt_next = init_cnt + (ADDR_W+1)'(1);

   // Select and data only change on edges where the operation pin is high,
   // so the transparent array never sees them move during a write pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INIT_SETUP;
         init_cnt      <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         init_done     <= 1'b0;
         mem_operation <= OP_READ;
         mem_select    <= '0;
         mem_data_in   <= '0;
         mem_enable    <= 1'b0;
      end else begin
         case (state)
            INIT_SETUP: begin
               mem_select    <= init_cnt[ADDR_W-1:0];
               mem_data_in   <= INIT_VAL;
               mem_enable    <= 1'b1;
               mem_operation <= OP_WRITE;
               state         <= INIT_PULSE;
            end
            INIT_PULSE: begin
               mem_operation <= OP_READ;
               state         <= INIT_HOLD;
            end
            INIT_HOLD: begin
               if (init_cnt == LAST_CNT) begin
                  init_done  <= 1'b1;
                  req_ready  <= 1'b1;
                  mem_enable <= 1'b0;
                  state      <= IDLE;
               end else begin
                  init_cnt   <= cnt_next;
                  mem_select <= cnt_next[ADDR_W-1:0];
                  state      <= INIT_SETUP;
               end
            end
            IDLE: begin
               mem_operation <= OP_READ;
               if (req_valid && req_ready) begin
                  req_ready  <= 1'b0;
                  mem_select <= req_addr;
                  mem_enable <= 1'b1;
                  if (req_write) begin
                     mem_data_in <= req_wdata;
                     state       <= W_SETUP;
                  end else begin
                     state <= R_SETUP;
                  end
               end
            end
            W_SETUP: begin
               mem_operation <= OP_WRITE;
               state         <= W_PULSE;
            end
            W_PULSE: begin
               mem_operation <= OP_READ;
               state         <= W_HOLD;
            end
            W_HOLD: begin
               mem_enable <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            R_SETUP: begin
               rsp_rdata  <= mem_data_out;
               rsp_valid  <= 1'b1;
               mem_enable <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               init_cnt <= '0;
               state    <= INIT_SETUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural model of the 4x4 array.
module tb_sram_ctrl;
   import sram_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_write = 1'b0;
   logic [1:0] req_addr = '0;
   logic [3:0] req_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_rdata;
   logic       init_done;
   logic [1:0] mem_select;
   logic       mem_operation;
   logic       mem_enable;
   logic [3:0] mem_data_in;
   logic [3:0] mem_data_out;

   sram_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .init_done(init_done),
      .mem_select(mem_select), .mem_operation(mem_operation),
      .mem_enable(mem_enable), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Array model: preloaded with garbage so the clear is actually observed.
   logic       preload = 1'b1;
   logic [3:0] arr [4];
   assign mem_data_out = arr[mem_select];

   always @(negedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4; i++) arr[i] <= 4'h9;
      end else if (mem_enable && mem_operation == OP_WRITE) begin
         arr[mem_select] <= mem_data_in;
      end
   end

   // Write-pulse monitor: counts low cycles, pulses and select/data motion
   // across pulse boundaries.
   int         cyc = 0;
   int         low_cycles = 0;
   int         pulse_cnt = 0;
   int         glitch_cnt = 0;
   logic [1:0] last_pulse_sel = '0;
   logic       prev_op = 1'b1;
   logic [1:0] prev_sel = '0;
   logic [3:0] prev_din = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_operation === 1'b0) begin
         low_cycles     <= low_cycles + 1;
         last_pulse_sel <= mem_select;
         if (prev_op === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            if (mem_select !== prev_sel || mem_data_in !== prev_din)
               glitch_cnt <= glitch_cnt + 1;
         end
      end else if (prev_op === 1'b0) begin
         if (mem_select !== prev_sel || mem_data_in !== prev_din)
            glitch_cnt <= glitch_cnt + 1;
      end
      prev_op  <= mem_operation;
      prev_sel <= mem_select;
      prev_din <= mem_data_in;
   end

   int         nchecks = 0;
   int         nfail = 0;
   logic [3:0] exp_mem [4];
   logic [3:0] sb [$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(output int acc_cyc);
      int n = 0;
      while (!req_ready && n < 40) begin
         tick();
         n++;
      end
      nchecks++;
      if (req_ready !== 1'b1) begin
         nfail++;
         $display("FAIL accept_timeout: req_ready=%0b required 1 within 40 cycles", req_ready);
      end
      tick();
      acc_cyc = cyc;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [3:0] d, input bit keep,
                           output int acc_cyc);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = d;
      wait_accept(acc_cyc);
      exp_mem[a] = d;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, input int hold);
      int         acc;
      int         n = 0;
      logic [3:0] d0;
      logic [3:0] exp;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
      rsp_ready = (hold == 0);
      sb.push_back(exp_mem[a]);
      wait_accept(acc);
      req_valid = 1'b0;
      nchecks++;
      if (rsp_valid !== 1'b0) begin
         nfail++;
         $display("FAIL rsp_early: rsp_valid=%0b required 0 in R_SETUP", rsp_valid);
      end
      while (!rsp_valid && n < 10) begin
         tick();
         n++;
      end
      nchecks++;
      if (rsp_valid !== 1'b1 || (cyc - acc) != 1) begin
         nfail++;
         $display("FAIL rsp_latency: rsp_valid=%0b after %0d edges, required 1 after 1 edge",
                  rsp_valid, cyc - acc);
      end
      d0 = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         nchecks++;
         if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, d0}) begin
            nfail++;
            $display("FAIL rsp_hold: valid=%0b ready=%0b rdata=%h required 1 0 %h",
                     rsp_valid, req_ready, rsp_rdata, d0);
         end
         tick();
      end
      rsp_ready = 1'b1;
      exp = (sb.size() > 0) ? sb.pop_front() : 4'hx;
      nchecks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
         nfail++;
         $display("FAIL rsp_data addr %0d: valid=%0b rdata=%h required 1 %h",
                  a, rsp_valid, rsp_rdata, exp);
      end
      tick();
      rsp_ready = 1'b0;
      nchecks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         nfail++;
         $display("FAIL rsp_release: valid=%0b ready=%0b required 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic do_reset;
      int low0;
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      sb.delete();
      tick();
      nchecks++;
      if ({req_ready, rsp_valid, rsp_rdata, init_done, mem_operation, mem_select,
           mem_data_in, mem_enable} !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 1'b0}) begin
         nfail++;
         $display("FAIL reset_values: rdy=%0b vld=%0b rdata=%h done=%0b op=%0b sel=%0d din=%h en=%0b required 0 0 0 0 1 0 0 0",
                  req_ready, rsp_valid, rsp_rdata, init_done, mem_operation, mem_select,
                  mem_data_in, mem_enable);
      end
      rst  = 1'b0;
      low0 = low_cycles;
      for (int i = 1; i <= 12; i++) begin
         tick();
         nchecks++;
         if ({init_done, req_ready} !== ((i == 12) ? 2'b11 : 2'b00)) begin
            nfail++;
            $display("FAIL clear_timing cycle %0d: init_done=%0b req_ready=%0b required %0b",
                     i, init_done, req_ready, (i == 12));
         end
      end
      nchecks++;
      if (low_cycles - low0 != 4) begin
         nfail++;
         $display("FAIL clear_pulses: %0d write-pulse cycles, required 4", low_cycles - low0);
      end
      for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      preload = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) do_read(2'(i), 0);
   endtask

   task automatic test_write_read;
      int acc, low0, p0, g0;
      low0 = low_cycles;
      p0   = pulse_cnt;
      g0   = glitch_cnt;
      do_write(2'd2, 4'hA, 1'b0, acc);
      repeat (4) tick();
      nchecks++;
      if (low_cycles - low0 != 1 || pulse_cnt - p0 != 1 || last_pulse_sel !== 2'd2) begin
         nfail++;
         $display("FAIL write_pulse: low=%0d pulses=%0d sel=%0d required 1 1 2",
                  low_cycles - low0, pulse_cnt - p0, last_pulse_sel);
      end
      nchecks++;
      if (glitch_cnt != g0) begin
         nfail++;
         $display("FAIL write_glitch: %0d select/data changes at pulse edges, required 0",
                  glitch_cnt - g0);
      end
      do_read(2'd2, 0);
   endtask

   task automatic test_hold;
      int acc;
      do_write(2'd1, 4'h5, 1'b0, acc);
      do_read(2'd1, 5);
   endtask

   task automatic test_back_to_back;
      int a0, a1, a2, a3;
      do_write(2'd0, 4'h1, 1'b1, a0);
      do_write(2'd1, 4'h2, 1'b1, a1);
      do_write(2'd2, 4'h3, 1'b1, a2);
      do_write(2'd3, 4'hF, 1'b0, a3);
      nchecks++;
      if (a1 - a0 != 4 || a2 - a1 != 4 || a3 - a2 != 4) begin
         nfail++;
         $display("FAIL b2b_spacing: gaps %0d %0d %0d required 4 4 4", a1 - a0, a2 - a1, a3 - a2);
      end
      for (int i = 0; i < 4; i++) do_read(2'(i), 0);
   endtask

   task automatic test_rst_write;
      int acc;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 2'd3;
      req_wdata = 4'h7;
      wait_accept(acc);
      req_valid = 1'b0;
      tick();
      nchecks++;
      if (mem_operation !== 1'b0) begin
         nfail++;
         $display("FAIL w_pulse_reached: mem_operation=%0b required 0", mem_operation);
      end
      do_reset();
      do_read(2'd3, 0);
   endtask

   task automatic test_rst_resp;
      int acc;
      do_write(2'd0, 4'hC, 1'b0, acc);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 2'd0;
      rsp_ready = 1'b0;
      sb.push_back(4'hC);
      wait_accept(acc);
      req_valid = 1'b0;
      tick();
      nchecks++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 4'hC}) begin
         nfail++;
         $display("FAIL resp_pending: valid=%0b rdata=%h required 1 c", rsp_valid, rsp_rdata);
      end
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         nchecks++;
         if (rsp_valid !== 1'b0) begin
            nfail++;
            $display("FAIL stale_resp cycle %0d: rsp_valid=%0b required 0", i, rsp_valid);
         end
      end
      nchecks++;
      if (sb.size() != 0) begin
         nfail++;
         $display("FAIL scoreboard_left: %0d entries required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_hold();
      test_back_to_back();
      test_rst_write();
      test_rst_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule
